// File: rtl/serial_tx_sched_if.sv
// Bus between the frame scheduler, its four word sources and the serial_tx
// link it feeds. Source handshake: req[k] is a level "valid" that the source
// holds, with its word stable on d_in, until ack[k] pulses for one clock.
// That ack pulse is the only transfer event. A source may drop req without
// being served. The link side has no back-pressure: the scheduler spaces
// sync pulses far enough apart that serial_tx is always ready.
interface serial_tx_sched_if;
  logic [7:0]   tick_div;
  logic         enable;
  logic [3:0]   req;
  logic [255:0] d_in;
  logic [3:0]   ack;
  logic         tick;
  logic         sync;
  logic [63:0]  d_out;
  logic [1:0]   src;
  logic         idle_frame;
  logic [15:0]  frames_sent;
  logic         dbg_state;
  logic [1:0]   dbg_rr_ptr;

  modport master (
    output tick_div, enable, req, d_in,
    input  ack, tick, sync, d_out, src, idle_frame, frames_sent,
    input  dbg_state, dbg_rr_ptr
  );

  modport slave (
    input  tick_div, enable, req, d_in,
    output ack, tick, sync, d_out, src, idle_frame, frames_sent,
    output dbg_state, dbg_rr_ptr
  );
endinterface

// File: rtl/serial_tx_sched.sv
// Frame scheduler and round-robin arbiter sharing one serial_tx link
// between four 64-bit word sources. Generates the bit-rate tick and issues
// one sync plus data word per FRAME_TICKS-tick slot.
module serial_tx_sched #(
  parameter int          FRAME_TICKS = 120,
  parameter bit          IDLE_FILL   = 1'b1,
  parameter logic [63:0] IDLE_WORD   = 64'h0
) (
  input logic              clk,
  input logic              rst,
  serial_tx_sched_if.slave bus
);

  // A slot must hold a 90-tick frame plus the 24-tick gap with some margin.
  if (FRAME_TICKS < 116 || FRAME_TICKS > 255) begin : g_bad_frame_ticks
    $error("serial_tx_sched: FRAME_TICKS must be in 116..255");
  end

  localparam logic [7:0] LAST_SLOT = 8'(FRAME_TICKS - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t       state;
  logic [7:0]   div_cnt;
  logic [7:0]   slot;
  logic [1:0]   rr_ptr;
  logic         tick_q;
  logic         sync_q;
  logic [3:0]   ack_q;
  logic [63:0]  d_out_q;
  logic [1:0]   src_q;
  logic         idle_q;
  logic [15:0]  fs_q;

  logic         tick_fire;
  logic         pend;
  logic         grant_valid;
  logic [1:0]   grant_idx;
  logic [63:0]  grant_word;

  // The wrapping tick is consumed by the arbiter in the same clock it
  // happens (the FSM is always back in IDLE long before the next wrap), so
  // the pending-slot flag never needs to be stored.
  assign tick_fire = (div_cnt == bus.tick_div);
  assign pend      = tick_fire && (slot == LAST_SLOT);

  // Divider wraps naturally at 255 if tick_div drops below the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      slot    <= '0;
      tick_q  <= 1'b0;
    end else begin
      tick_q <= tick_fire;
      if (tick_fire) begin
        div_cnt <= '0;
        slot    <= pend ? 8'd0 : slot + 8'd1;
      end else begin
        div_cnt <= div_cnt + 8'd1;
      end
    end
  end

  // First requester at or after rr_ptr; later offsets are overwritten by
  // earlier ones, so the lowest offset wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = rr_ptr;
    for (int i = 3; i >= 0; i--) begin
      if (bus.req[rr_ptr + 2'(i)]) begin
        grant_valid = 1'b1;
        grant_idx   = rr_ptr + 2'(i);
      end
    end
  end

  assign grant_word = bus.d_in[{grant_idx, 6'd0} +: 64];

  // Arbiter FSM: one GRANT clock per slot decides data, idle fill or nothing.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      rr_ptr  <= '0;
      sync_q  <= 1'b0;
      ack_q   <= '0;
      d_out_q <= '0;
      src_q   <= '0;
      idle_q  <= 1'b0;
      fs_q    <= '0;
    end else begin
      sync_q <= 1'b0;
      ack_q  <= '0;
      case (state)
        S_IDLE: begin
          if (pend) state <= S_GRANT;
        end
        S_GRANT: begin
          state <= S_IDLE;
          if (bus.enable && grant_valid) begin
            d_out_q <= grant_word;
            src_q   <= grant_idx;
            idle_q  <= 1'b0;
            ack_q   <= 4'b0001 << grant_idx;
            sync_q  <= 1'b1;
            fs_q    <= fs_q + 16'd1;
            rr_ptr  <= grant_idx + 2'd1;
          end else if (bus.enable && IDLE_FILL) begin
            d_out_q <= IDLE_WORD;
            src_q   <= 2'd0;
            idle_q  <= 1'b1;
            sync_q  <= 1'b1;
            fs_q    <= fs_q + 16'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.tick        = tick_q;
  assign bus.sync        = sync_q;
  assign bus.ack         = ack_q;
  assign bus.d_out       = d_out_q;
  assign bus.src         = src_q;
  assign bus.idle_frame  = idle_q;
  assign bus.frames_sent = fs_q;
  assign bus.dbg_state   = state;
  assign bus.dbg_rr_ptr  = rr_ptr;

endmodule

// File: tb/tb_serial_tx_sched.sv
// Bench for serial_tx_sched: scenario tasks plus randomized traffic checked
// against a slot-level model (grant instants, round-robin order, fill words).
module tb_serial_tx_sched;
  localparam int          FT   = 120;
  localparam logic [63:0] FILL = 64'hA5A5_A5A5_A5A5_A5A5;

  logic clk = 1'b0;
  logic rst = 1'b1;

  serial_tx_sched_if bus();
  serial_tx_sched_if nf();

  serial_tx_sched #(.FRAME_TICKS(FT), .IDLE_FILL(1'b1), .IDLE_WORD(FILL))
    dut (.clk(clk), .rst(rst), .bus(bus));
  serial_tx_sched #(.FRAME_TICKS(FT), .IDLE_FILL(1'b0), .IDLE_WORD(FILL))
    dut_nf (.clk(clk), .rst(rst), .bus(nf));

  assign nf.tick_div = bus.tick_div;
  assign nf.enable   = bus.enable;
  assign nf.req      = bus.req;
  assign nf.d_in     = bus.d_in;

  // Clock / reset block
  always #4 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc, tick_cnt, first_tick, dout_glitch, nf_sync_cnt, rq_mode;
  int model_rr, model_fs, model_nf_fs;
  logic [3:0]   req_hist[$];
  logic         en_hist[$];
  logic [255:0] dw_hist[$];
  // {clock[15:0], ack[3:0], idle, src[1:0], word[63:0]}
  logic [86:0]  exp_q[$];
  logic [86:0]  obs_q[$];
  int           obs_fs[$];

  task automatic clear_model();
    cyc = 0; tick_cnt = 0; first_tick = 0; dout_glitch = 0; nf_sync_cnt = 0;
    model_rr = 0; model_fs = 0; model_nf_fs = 0;
    req_hist.delete(); en_hist.delete(); dw_hist.delete();
    exp_q.delete(); obs_q.delete(); obs_fs.delete();
  endtask

  task automatic release_reset();
    rst = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    clear_model();
  endtask

  // Driver + monitor: steps n clocks, logs inputs seen by each edge, records
  // sync/ack events and plays the source side of the handshake.
  task automatic run_clocks(input int n);
    logic [63:0] prev_dout;
    for (int i = 0; i < n; i++) begin
      req_hist.push_back(bus.req);
      en_hist.push_back(bus.enable);
      dw_hist.push_back(bus.d_in);
      prev_dout = bus.d_out;
      @(posedge clk); #1;
      cyc++;
      if (bus.tick) begin
        tick_cnt++;
        if (first_tick == 0) first_tick = cyc;
      end
      if (bus.sync || bus.ack != 4'b0) begin
        obs_q.push_back({16'(cyc), bus.ack, bus.idle_frame, bus.src, bus.d_out});
        obs_fs.push_back(int'(bus.frames_sent));
      end
      if (!bus.sync && bus.d_out !== prev_dout) dout_glitch++;
      if (nf.sync) nf_sync_cnt++;
      for (int k = 0; k < 4; k++) begin
        if (bus.ack[k]) begin
          if (rq_mode == 1 || (rq_mode == 2 && $urandom_range(0, 1) == 0)) bus.req[k] = 1'b0;
          else bus.d_in[64*k +: 64] = {$urandom, $urandom};
        end
      end
      if (rq_mode == 2) begin
        int k;
        k = $urandom_range(0, 3);
        if ($urandom_range(0, 63) == 0 && !bus.req[k]) begin
          bus.d_in[64*k +: 64] = {$urandom, $urandom};
          bus.req[k] = 1'b1;
        end
        if ($urandom_range(0, 299) == 0) bus.enable = !bus.enable;
      end
    end
  endtask

  // Reference model: slot s is decided by the edge at clock s*period+1 from
  // the inputs present just before that edge.
  task automatic model_slots(input int period);
    int nslots;
    nslots = (cyc - 1) / period;
    for (int s = 1; s <= nslots; s++) begin
      int c, k;
      logic [3:0] r;
      logic en;
      logic [255:0] w;
      c = s * period + 1;
      r = req_hist[c-1];
      en = en_hist[c-1];
      w = dw_hist[c-1];
      k = -1;
      for (int j = 0; j < 4; j++) begin
        if (k < 0 && r[(model_rr + j) % 4]) k = (model_rr + j) % 4;
      end
      if (en && k >= 0) begin
        exp_q.push_back({16'(c), 4'(1 << k), 1'b0, 2'(k), w[64*k +: 64]});
        model_rr = (k + 1) % 4;
        model_fs++;
        model_nf_fs++;
      end else if (en) begin
        exp_q.push_back({16'(c), 4'b0, 1'b1, 2'b0, FILL});
        model_fs++;
      end
    end
  endtask

  task automatic test_reset();
    bus.tick_div = 8'($urandom_range(0, 7));
    bus.enable = 1'b1;
    bus.req = 4'($urandom);
    bus.d_in = {8{$urandom}};
    rq_mode = 1;
    rst = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    checks += 9;
    if (bus.tick !== 1'b0) begin failures++; $display("FAIL reset_tick got %b want 0", bus.tick); end
    if (bus.sync !== 1'b0) begin failures++; $display("FAIL reset_sync got %b want 0", bus.sync); end
    if (bus.ack !== 4'b0) begin failures++; $display("FAIL reset_ack got %b want 0000", bus.ack); end
    if (bus.d_out !== 64'h0) begin failures++; $display("FAIL reset_d_out got %h want 0", bus.d_out); end
    if (bus.src !== 2'd0) begin failures++; $display("FAIL reset_src got %0d want 0", bus.src); end
    if (bus.idle_frame !== 1'b0) begin failures++; $display("FAIL reset_idle got %b want 0", bus.idle_frame); end
    if (bus.frames_sent !== 16'd0) begin failures++; $display("FAIL reset_fs got %0d want 0", bus.frames_sent); end
    if (bus.dbg_state !== 1'b0) begin failures++; $display("FAIL reset_state got %b want 0", bus.dbg_state); end
    if (bus.dbg_rr_ptr !== 2'd0) begin failures++; $display("FAIL reset_rr got %0d want 0", bus.dbg_rr_ptr); end
  endtask

  task automatic test_first_frame();
    logic [86:0] e0, e1;
    bus.tick_div = 8'd3;
    bus.enable = 1'b1;
    bus.req = 4'b0001;
    bus.d_in = '0;
    bus.d_in[63:0] = 64'hDEADBEEF_01234567;
    rq_mode = 1;
    release_reset();
    run_clocks(965);
    model_slots(FT * 4);
    e0 = (obs_q.size() > 0) ? obs_q[0] : '0;
    e1 = (obs_q.size() > 1) ? obs_q[1] : '0;
    checks += 10;
    if (first_tick !== 4) begin failures++; $display("FAIL first_tick got %0d want 4", first_tick); end
    if (e0[86:71] !== 16'd481) begin failures++; $display("FAIL first_sync_clk got %0d want 481", e0[86:71]); end
    if (e0[70:67] !== 4'b0001) begin failures++; $display("FAIL first_ack got %b want 0001", e0[70:67]); end
    if (e0[63:0] !== 64'hDEADBEEF_01234567) begin failures++; $display("FAIL first_word got %h want deadbeef01234567", e0[63:0]); end
    if (e0[66:64] !== 3'b000) begin failures++; $display("FAIL first_idle_src got %b want 000", e0[66:64]); end
    if (e1[86:71] !== 16'd961) begin failures++; $display("FAIL second_sync_clk got %0d want 961", e1[86:71]); end
    if (e1[66] !== 1'b1 || e1[63:0] !== FILL) begin failures++; $display("FAIL second_fill got idle=%b %h want idle=1 %h", e1[66], e1[63:0], FILL); end
    if (bus.frames_sent !== 16'd2) begin failures++; $display("FAIL first_fs got %0d want 2", bus.frames_sent); end
    if (dout_glitch !== 0) begin failures++; $display("FAIL first_dout_stable got %0d changes want 0", dout_glitch); end
    if (obs_q.size() !== exp_q.size()) begin failures++; $display("FAIL first_count got %0d want %0d", obs_q.size(), exp_q.size()); end
  endtask

  task automatic test_round_robin();
    bus.tick_div = 8'd0;
    bus.enable = 1'b1;
    bus.req = 4'b1111;
    bus.d_in = {8{$urandom}};
    rq_mode = 0;
    release_reset();
    run_clocks(5 * FT + 5);
    model_slots(FT);
    checks++;
    if (obs_q.size() !== 5) begin failures++; $display("FAIL rr_count got %0d want 5", obs_q.size()); end
    for (int i = 0; i < 5 && i < obs_q.size(); i++) begin
      checks += 4;
      if (obs_q[i][65:64] !== 2'(i % 4)) begin failures++; $display("FAIL rr_src[%0d] got %0d want %0d", i, obs_q[i][65:64], i % 4); end
      if (obs_q[i][86:71] !== 16'(FT * (i + 1) + 1)) begin failures++; $display("FAIL rr_clk[%0d] got %0d want %0d", i, obs_q[i][86:71], FT * (i + 1) + 1); end
      if (obs_fs[i] !== i + 1) begin failures++; $display("FAIL rr_fs[%0d] got %0d want %0d", i, obs_fs[i], i + 1); end
      if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL rr_event[%0d] got %h want %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_idle_fill();
    int d, p;
    d = $urandom_range(0, 2);
    p = FT * (d + 1);
    bus.tick_div = 8'(d);
    bus.enable = 1'b1;
    bus.req = 4'b0000;
    rq_mode = 1;
    release_reset();
    run_clocks(3 * p + 2);
    checks += 4;
    if (obs_q.size() !== 3) begin failures++; $display("FAIL idle_count got %0d want 3", obs_q.size()); end
    if (nf_sync_cnt !== 0) begin failures++; $display("FAIL nofill_sync got %0d want 0", nf_sync_cnt); end
    if (nf.frames_sent !== 16'd0) begin failures++; $display("FAIL nofill_fs got %0d want 0", nf.frames_sent); end
    if (bus.frames_sent !== 16'd3) begin failures++; $display("FAIL idle_fs got %0d want 3", bus.frames_sent); end
    bus.d_in[191:128] = {$urandom, $urandom};
    bus.req = 4'b0100;
    run_clocks(p);
    run_clocks(2 * p);
    model_slots(p);
    checks += 3;
    if (bus.dbg_rr_ptr !== 2'd3) begin failures++; $display("FAIL idle_rr_hold got %0d want 3", bus.dbg_rr_ptr); end
    if (nf.frames_sent !== 16'd1) begin failures++; $display("FAIL nofill_fs2 got %0d want 1", nf.frames_sent); end
    if (obs_q.size() !== exp_q.size()) begin failures++; $display("FAIL idle_total got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL idle_event[%0d] got %h want %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_enable_gate();
    logic [86:0] e0, e1;
    bus.tick_div = 8'd0;
    bus.enable = 1'b0;
    bus.req = 4'b0100;
    bus.d_in = {8{$urandom}};
    rq_mode = 1;
    release_reset();
    run_clocks(300);
    checks += 2;
    if (obs_q.size() !== 0) begin failures++; $display("FAIL dis_events got %0d want 0", obs_q.size()); end
    if (tick_cnt !== 300) begin failures++; $display("FAIL dis_ticks got %0d want 300", tick_cnt); end
    bus.enable = 1'b1;
    run_clocks(180);
    bus.d_in[127:64] = {$urandom, $urandom};
    bus.req = 4'b0010;
    bus.enable = 1'b0;
    run_clocks(1);
    bus.enable = 1'b1;
    run_clocks(121);
    model_slots(FT);
    e0 = (obs_q.size() > 0) ? obs_q[0] : '0;
    e1 = (obs_q.size() > 1) ? obs_q[1] : '0;
    checks += 5;
    if (e0[86:71] !== 16'd361 || e0[70:67] !== 4'b0100) begin failures++; $display("FAIL reenable_grant got clk=%0d ack=%b want clk=361 ack=0100", e0[86:71], e0[70:67]); end
    if (e1[86:71] !== 16'd601 || e1[70:67] !== 4'b0010) begin failures++; $display("FAIL late_disable got clk=%0d ack=%b want clk=601 ack=0010", e1[86:71], e1[70:67]); end
    if (obs_q.size() !== 2) begin failures++; $display("FAIL enable_count got %0d want 2", obs_q.size()); end
    if (obs_q.size() !== exp_q.size()) begin failures++; $display("FAIL enable_model_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    if (bus.frames_sent !== 16'(model_fs)) begin failures++; $display("FAIL enable_fs got %0d want %0d", bus.frames_sent, model_fs); end
  endtask

  task automatic test_mid_reset();
    logic [86:0] e0;
    bus.tick_div = 8'd0;
    bus.enable = 1'b1;
    bus.req = 4'b1111;
    bus.d_in = {8{$urandom}};
    rq_mode = 0;
    release_reset();
    run_clocks(FT + 11);
    rst = 1'b1;
    bus.tick_div = 8'd1;
    @(posedge clk); #1;
    checks++;
    if ({bus.tick, bus.sync, bus.ack, bus.d_out, bus.src, bus.idle_frame, bus.frames_sent} !== '0) begin
      failures++;
      $display("FAIL midrst_zero got tick=%b sync=%b ack=%b d=%h src=%0d idle=%b fs=%0d want all 0",
               bus.tick, bus.sync, bus.ack, bus.d_out, bus.src, bus.idle_frame, bus.frames_sent);
    end
    rst = 1'b0;
    clear_model();
    run_clocks(2 * FT + 5);
    e0 = (obs_q.size() > 0) ? obs_q[0] : '0;
    checks++;
    if (e0[86:71] !== 16'(2 * FT + 1)) begin failures++; $display("FAIL midrst_holdoff got %0d want %0d", e0[86:71], 2 * FT + 1); end
    run_clocks(4 * FT - cyc);
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.ack !== 4'b0 || bus.sync !== 1'b0) begin failures++; $display("FAIL grant_rst got ack=%b sync=%b want 0000 0", bus.ack, bus.sync); end
    rst = 1'b0;
  endtask

  task automatic test_random(input int d, input int nslots);
    int p, min_gap;
    p = FT * (d + 1);
    bus.tick_div = 8'(d);
    bus.enable = 1'b1;
    bus.req = 4'($urandom);
    bus.d_in = {8{$urandom}};
    rq_mode = 2;
    release_reset();
    run_clocks(nslots * p + 3);
    model_slots(p);
    min_gap = 1 << 30;
    for (int i = 1; i < obs_q.size(); i++) begin
      if (int'(obs_q[i][86:71]) - int'(obs_q[i-1][86:71]) < min_gap)
        min_gap = int'(obs_q[i][86:71]) - int'(obs_q[i-1][86:71]);
    end
    checks += 6;
    if (obs_q.size() !== exp_q.size()) begin failures++; $display("FAIL rand%0d_count got %0d want %0d", d, obs_q.size(), exp_q.size()); end
    if (tick_cnt !== cyc / (d + 1)) begin failures++; $display("FAIL rand%0d_ticks got %0d want %0d", d, tick_cnt, cyc / (d + 1)); end
    if (dout_glitch !== 0) begin failures++; $display("FAIL rand%0d_dout_stable got %0d want 0", d, dout_glitch); end
    if (bus.frames_sent !== 16'(model_fs)) begin failures++; $display("FAIL rand%0d_fs got %0d want %0d", d, bus.frames_sent, model_fs); end
    if (nf.frames_sent !== 16'(model_nf_fs)) begin failures++; $display("FAIL rand%0d_nofill_fs got %0d want %0d", d, nf.frames_sent, model_nf_fs); end
    if (min_gap < 114 * (d + 1)) begin failures++; $display("FAIL rand%0d_overlap got gap %0d want >= %0d", d, min_gap, 114 * (d + 1)); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL rand%0d_event[%0d] got %h want %h", d, i, obs_q[i], exp_q[i]); end
    end
  endtask

  initial begin
    bus.tick_div = 8'd0;
    bus.enable = 1'b0;
    bus.req = 4'b0;
    bus.d_in = '0;
    rq_mode = 1;
    clear_model();
    test_reset();
    test_first_frame();
    test_round_robin();
    test_idle_fill();
    test_enable_gate();
    test_mid_reset();
    test_random(0, 20);
    test_random(7, 6);
    test_random($urandom_range(1, 3), 8);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
